phy_header_gen: RTL and testbench



---
 rtl/phy_pkg.sv | 25 ++
 rtl/phy_crc16_tx.sv | 35 +++
 rtl/phy_header_gen.sv | 161 ++++++++++++++++
 tb/tb_phy_header_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared constants, state encoding and CRC step for the PLCP transmit framer
package phy_pkg;

    localparam logic [15:0] SFD_LONG       = 16'hF3A0;
    localparam logic [15:0] SFD_SHORT      = 16'h05CF;
    localparam logic [7:0]  SIGNAL_1M      = 8'h0A;
    localparam logic [15:0] CRC16_POLY     = 16'h1021;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam int          SHORT_SYNC_LEN = 56;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_HDR  = 3'd3;
    localparam logic [2:0] ST_CRC  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // One serial step of the CCITT CRC, MSB-feedback form.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/phy_crc16_tx.sv
// rtl/phy_crc16_tx.sv - serial CCITT CRC-16 register with preset and enable
import phy_pkg::*;

module phy_crc16_tx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic        data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/phy_header_gen.sv
// rtl/phy_header_gen.sv - 802.11b DSSS PLCP preamble/header serialiser; PHY_SHORT_PREAMBLE_EN adds short preamble
import phy_pkg::*;

module phy_header_gen #(
    parameter int          SYNC_LEN    = 128,
    parameter logic [15:0] SFD_LONG    = phy_pkg::SFD_LONG,
    parameter logic [7:0]  SERVICE_DEF = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_start,
    input  logic [7:0]  pkt_rate,
    input  logic [15:0] pkt_len,
`ifdef PHY_SHORT_PREAMBLE_EN
    input  logic        tx_short_pre,
`endif
    input  logic        bit_ready,
    output logic        tx_bit,
    output logic        tx_bit_valid,
    output logic        tx_busy,
    output logic        hdr_done
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  sync_cnt_q, sync_cnt_d;
    logic [5:0]  fld_cnt_q, fld_cnt_d;
    logic [31:0] hdr_q, hdr_d;
    logic [15:0] crc_reg;
    logic        use_short;
    logic        advance;
    logic        accept;
    logic [7:0]  sync_last;
    logic [15:0] sfd_sel;

`ifdef PHY_SHORT_PREAMBLE_EN
    logic short_q, short_d;

    always_comb begin
        short_d = short_q;
        if (accept) begin
            short_d = tx_short_pre;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            short_q <= 1'b0;
        end else begin
            short_q <= short_d;
        end
    end

    assign use_short = short_q;
`else
    assign use_short = 1'b0;
`endif

    assign tx_bit_valid = (state_q == ST_SYNC) || (state_q == ST_SFD) ||
                          (state_q == ST_HDR)  || (state_q == ST_CRC);
    assign tx_busy      = (state_q != ST_IDLE);
    assign hdr_done     = (state_q == ST_DONE);
    assign advance      = bit_ready && tx_bit_valid;
    assign accept       = (state_q == ST_IDLE) && tx_start;
    assign sync_last    = use_short ? 8'(SHORT_SYNC_LEN - 1) : 8'(SYNC_LEN - 1);
    assign sfd_sel      = use_short ? SFD_SHORT : SFD_LONG;

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        fld_cnt_d  = fld_cnt_q;
        hdr_d      = hdr_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    hdr_d      = {pkt_len, SERVICE_DEF, pkt_rate};
                    sync_cnt_d = 8'd0;
                    fld_cnt_d  = 6'd0;
                    state_d    = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (advance) begin
                    if (sync_cnt_q == sync_last) begin
                        sync_cnt_d = 8'd0;
                        state_d    = ST_SFD;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 8'd1;
                    end
                end
            end
            ST_SFD: begin
                if (advance) begin
                    if (fld_cnt_q == 6'd15) begin
                        fld_cnt_d = 6'd0;
                        state_d   = ST_HDR;
                    end else begin
                        fld_cnt_d = fld_cnt_q + 6'd1;
                    end
                end
            end
            ST_HDR: begin
                if (advance) begin
                    if (fld_cnt_q == 6'd31) begin
                        fld_cnt_d = 6'd0;
                        state_d   = ST_CRC;
                    end else begin
                        fld_cnt_d = fld_cnt_q + 6'd1;
                    end
                end
            end
            ST_CRC: begin
                if (advance) begin
                    if (fld_cnt_q == 6'd15) begin
                        fld_cnt_d = 6'd0;
                        state_d   = ST_DONE;
                    end else begin
                        fld_cnt_d = fld_cnt_q + 6'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // CRC goes out complemented, x^15 term first.
    always_comb begin
        tx_bit = 1'b0;
        case (state_q)
            ST_SYNC: tx_bit = ~use_short;
            ST_SFD:  tx_bit = sfd_sel[fld_cnt_q[3:0]];
            ST_HDR:  tx_bit = hdr_q[fld_cnt_q[4:0]];
            ST_CRC:  tx_bit = ~crc_reg[4'd15 - fld_cnt_q[3:0]];
            default: tx_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sync_cnt_q <= 8'd0;
            fld_cnt_q  <= 6'd0;
            hdr_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            fld_cnt_q  <= fld_cnt_d;
            hdr_q      <= hdr_d;
        end
    end

    phy_crc16_tx u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (accept),
        .en      (advance && (state_q == ST_HDR)),
        .data    (hdr_q[fld_cnt_q[4:0]]),
        .crc     (crc_reg)
    );

endmodule

// File: tb/tb_phy_header_gen.sv
// tb/tb_phy_header_gen.sv - scoreboard bench for phy_header_gen, default long-preamble build
module tb_phy_header_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tx_start;
    logic [7:0]  pkt_rate;
    logic [15:0] pkt_len;
    logic        bit_ready;
    logic        tx_bit;
    logic        tx_bit_valid;
    logic        tx_busy;
    logic        hdr_done;

    int checks   = 0;
    int failures = 0;

    bit          exp_q[$];
    int          rx_cnt;
    logic [6:0]  scr_s, dsc_s;
    logic [47:0] rx_hdr;
    logic        held_bit;

    always #5 clk = ~clk;

    phy_header_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_start     (tx_start),
        .pkt_rate     (pkt_rate),
        .pkt_len      (pkt_len),
        .bit_ready    (bit_ready),
        .tx_bit       (tx_bit),
        .tx_bit_valid (tx_bit_valid),
        .tx_busy      (tx_busy),
        .hdr_done     (hdr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: divide the 32 header bits (LSB first) by x^16+x^12+x^5+1, preset ones.
    function automatic logic [15:0] gold_crc(input logic [31:0] h);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (r[15] != h[i]) r = (r << 1) ^ 16'h1021;
            else               r = r << 1;
        end
        return ~r;
    endfunction

    task automatic push_frame(input logic [7:0] rate, input logic [15:0] len);
        logic [15:0] sfd;
        logic [31:0] h;
        logic [15:0] c;
        sfd = 16'hF3A0;
        h   = {len, 8'h00, rate};
        c   = gold_crc(h);
        for (int i = 0; i < 128; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 16; i++)  exp_q.push_back(sfd[i]);
        for (int i = 0; i < 32; i++)  exp_q.push_back(h[i]);
        for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
    endtask

    task automatic start_frame(input logic [7:0] rate, input logic [15:0] len);
        @(negedge clk);
        pkt_rate = rate;
        pkt_len  = len;
        tx_start = 1'b1;
        push_frame(rate, len);
        rx_cnt = 0;
        scr_s  = 7'h1B;
        dsc_s  = 7'h1B;
        rx_hdr = '0;
        @(negedge clk);
        tx_start = 1'b0;
        pkt_rate = 8'h00;
        pkt_len  = 16'h0000;
        chk("start_valid", tx_bit_valid, 1);
        chk("start_bit", tx_bit, 1);
        chk("start_busy", tx_busy, 1);
    endtask

    // Consume n bits at one bit_ready every 4 cycles, via scrambler/descrambler into the rx capture.
    task automatic consume(input int n);
        bit   e;
        logic s_out, d_out;
        for (int k = 0; k < n; k++) begin
            chk("bit_valid", tx_bit_valid, 1);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_bit", tx_bit, e);
            end
            s_out = tx_bit ^ scr_s[3] ^ scr_s[6];
            scr_s = {scr_s[5:0], s_out};
            d_out = s_out ^ dsc_s[3] ^ dsc_s[6];
            dsc_s = {dsc_s[5:0], s_out};
            if (rx_cnt >= 144 && rx_cnt < 192) rx_hdr[rx_cnt - 144] = d_out;
            rx_cnt++;
            bit_ready = 1'b1;
            @(negedge clk);
            bit_ready = 1'b0;
            if (rx_cnt == 192) begin
                chk("done_pulse", hdr_done, 1);
                chk("done_valid", tx_bit_valid, 0);
                chk("done_busy", tx_busy, 1);
                @(negedge clk);
                chk("idle_done", hdr_done, 0);
                chk("idle_busy", tx_busy, 0);
                repeat (2) @(negedge clk);
            end else begin
                chk("no_early_done", hdr_done, 0);
                repeat (3) @(negedge clk);
            end
        end
    endtask

    task automatic check_rx(input logic [7:0] rate, input logic [15:0] len);
        logic [15:0] rx_crc;
        for (int i = 0; i < 16; i++) rx_crc[15 - i] = rx_hdr[32 + i];
        chk("rx_hdr_crc", rx_crc, gold_crc(rx_hdr[31:0]));
        chk("rx_len", rx_hdr[31:16], len);
        chk("rx_rate", rx_hdr[7:0], rate);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] lens [4];
        lens = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
        reset_n   = 1'b0;
        tx_start  = 1'b0;
        bit_ready = 1'b0;
        pkt_rate  = 8'h00;
        pkt_len   = 16'h0000;
        rx_cnt    = 0;
        scr_s     = 7'h1B;
        dsc_s     = 7'h1B;
        rx_hdr    = '0;
        repeat (3) @(negedge clk);
        chk("rst_bit", tx_bit, 0);
        chk("rst_valid", tx_bit_valid, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", hdr_done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        bit_ready = 1'b1;
        @(negedge clk);
        bit_ready = 1'b0;
        chk("idle_ready_ignored", tx_busy, 0);

        // Basic frame with back-pressure mid-SFD and a rejected start during HDR.
        start_frame(8'h0A, 16'h0100);
        consume(136);
        held_bit = tx_bit;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("stall_bit", tx_bit, held_bit);
            chk("stall_valid", tx_bit_valid, 1);
        end
        consume(24);
        tx_start = 1'b1;
        pkt_len  = 16'hFFFF;
        @(negedge clk);
        tx_start = 1'b0;
        pkt_len  = 16'h0000;
        chk("busy_reject", tx_busy, 1);
        consume(32);
        check_rx(8'h0A, 16'h0100);

        // Reset during the CRC state, then a fresh full frame.
        start_frame(8'h0A, 16'h0100);
        consume(180);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_bit", tx_bit, 0);
        chk("midrst_valid", tx_bit_valid, 0);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_done", hdr_done, 0);
        exp_q.delete();
        reset_n = 1'b1;
        @(negedge clk);
        start_frame(8'h0A, 16'h0100);
        consume(192);
        check_rx(8'h0A, 16'h0100);

        // Loopback over LENGTH corner values.
        foreach (lens[i]) begin
            start_frame(8'h0A, lens[i]);
            consume(192);
            check_rx(8'h0A, lens[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
